// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared register-file constants and the write-back entry type.
//   REG_ADDR_W : register index width (32 registers)
//   REG_DATA_W : register data width
//   REG_ZERO   : index of the hard-wired zero register; writes to it are dropped
//   wb_entry_t : one pending register write {rd, data}
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Ordered FIFO of pending register writes with two push lanes and one pop.
//   Lane 0 is always older than lane 1 when both push in the same cycle; the
//   lanes are compacted so a lone lane-1 push lands in the next free slot.
//   All entries are exposed in age order (index 0 = head/oldest) together
//   with per-slot valid bits so the owner can search pending writes.
//
// Ports
//   clk            rising-edge clock
//   rst_ni         asynchronous active-low reset (clears pointers and count)
//   push0_i        push lane 0 (older)
//   push0_entry_i  lane 0 entry
//   push1_i        push lane 1 (younger)
//   push1_entry_i  lane 1 entry
//   pop_i          remove head; caller guarantees the FIFO is non-empty
//   count_o        number of stored entries (0..DEPTH)
//   entries_o      stored entries, age ordered
//   valid_o        valid bit per age-ordered slot
//
//   The caller must never push more than the free slot count.
// -----------------------------------------------------------------------------
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push0_i,
  input  wb_entry_t                push0_entry_i,
  input  logic                     push1_i,
  input  wb_entry_t                push1_entry_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_entry_t                entries_o [DEPTH],
  output logic [DEPTH-1:0]         valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [CNT_W-1:0] count_q, count_d;

  wb_entry_t mem_q [DEPTH];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_i);
    count_d   = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: slots are only observed through valid_o.
  always_ff @(posedge clk) begin
    if (push0_i) begin
      mem_q[wr_ptr_q] <= push0_entry_i;
    end
    if (push1_i) begin
      mem_q[push0_i ? wr_ptr_p1 : wr_ptr_q] <= push1_entry_i;
    end
  end

  // Rotate storage into age order so the lookup can scan oldest->youngest.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    localparam logic [PTR_W-1:0] OFS = PTR_W'(gi);
    assign entries_o[gi] = mem_q[rd_ptr_q + OFS];
    assign valid_o[gi]   = (count_q > CNT_W'(gi));
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// reg_writeback_unit
//   Write-side driver for the 32x32 register file. Accepts results from the
//   load (mem) and ALU paths, queues them in program order and commits one
//   per cycle through the file's single write port. Pending writes can be
//   looked up so decode can bypass values that are not yet committed.
//
// Parameters
//   DEPTH   pending-write entries (power of two, >= 2)
//   DATA_W  register data width  (must equal cpu_pkg::REG_DATA_W)
//   ADDR_W  register index width (must equal cpu_pkg::REG_ADDR_W)
//
// Ports
//   clk, reset                     clock; asynchronous active-low reset
//   mem_valid/mem_rd/mem_data      load result; mem_ready = accepted
//   alu_valid/alu_rd/alu_data      ALU result;  alu_ready = accepted
//   regWrite/writeReg/writeData    register-file write port (from state only)
//   q1_reg/q1_hit/q1_data          lookup port 1 (youngest pending match)
//   q2_reg/q2_hit/q2_data          lookup port 2
//   busy                           at least one write pending
//   stat_commits, stat_stalls      only when WB_STATS_EN is defined
//
// Build option
//   WB_STATS_EN : adds 32-bit commit and stall counters.
// -----------------------------------------------------------------------------
module reg_writeback_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] q1_reg,
  input  logic [ADDR_W-1:0] q2_reg,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              busy
`ifdef WB_STATS_EN
  ,
  output logic [31:0]       stat_commits,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  wb_entry_t        mem_entry, alu_entry;
  logic             mem_push, alu_push, pop;

  // Readiness uses registered occupancy only; the same-cycle pop is not
  // credited, which keeps ready off the commit path.
  assign free      = DEPTH_C - count;
  assign mem_ready = (free != '0);
  assign alu_ready = (free >= CNT_W'(2)) || ((free != '0) && !mem_valid);

  // Writes to r0 complete the handshake but never occupy a slot.
  assign mem_push = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign alu_push = alu_valid && alu_ready && (alu_rd != REG_ZERO);

  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};

  // The register file never stalls, so the head retires every cycle.
  assign pop = (count != '0);

  // Lane 0 = load: it is older than an ALU result arriving in the same cycle.
  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_ni        (reset),
    .push0_i       (mem_push),
    .push0_entry_i (mem_entry),
    .push1_i       (alu_push),
    .push1_entry_i (alu_entry),
    .pop_i         (pop),
    .count_o       (count),
    .entries_o     (entries),
    .valid_o       (valid)
  );

  // Gate with pop so the port reads zero when idle (storage is not reset).
  assign regWrite  = pop;
  assign writeReg  = pop ? entries[0].rd   : '0;
  assign writeData = pop ? entries[0].data : '0;
  assign busy      = pop;

  // Scan oldest to youngest; a later match overwrites, so the youngest wins.
  // The head being committed this cycle is still valid and still searched.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k] && (q1_reg != REG_ZERO) && (entries[k].rd == q1_reg)) begin
        q1_hit  = 1'b1;
        q1_data = entries[k].data;
      end
      if (valid[k] && (q2_reg != REG_ZERO) && (entries[k].rd == q2_reg)) begin
        q2_hit  = 1'b1;
        q2_data = entries[k].data;
      end
    end
  end

`ifdef WB_STATS_EN
  logic [31:0] stat_commits_q, stat_commits_d;
  logic [31:0] stat_stalls_q,  stat_stalls_d;
  logic        stall;

  assign stall = (mem_valid && !mem_ready) || (alu_valid && !alu_ready);

  always_comb begin
    stat_commits_d = stat_commits_q + 32'(pop);
    stat_stalls_d  = stat_stalls_q  + 32'(stall);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_commits_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_commits_q <= stat_commits_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_commits = stat_commits_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_unit
//   Directed bench for reg_writeback_unit (DEPTH=4). Inputs change and
//   outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  q1_reg, q2_reg;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic        busy;
`ifdef WB_STATS_EN
  logic [31:0] stat_commits, stat_stalls;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_writeback_unit #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .q1_reg    (q1_reg),
    .q2_reg    (q2_reg),
    .q1_hit    (q1_hit),
    .q2_hit    (q2_hit),
    .q1_data   (q1_data),
    .q2_data   (q2_data),
    .busy      (busy)
`ifdef WB_STATS_EN
    ,
    .stat_commits (stat_commits),
    .stat_stalls  (stat_stalls)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  // Ready table rows {mem_valid, alu_valid, exp_mem_ready, exp_alu_ready}.
  // Occupancy before each row: 0,2,3,3,3,3,2 (one pop every busy cycle).
  logic [3:0]  tbl [7] = '{4'b1111, 4'b1111, 4'b1110, 4'b0111,
                           4'b1010, 4'b0011, 4'b1111};
  logic [36:0] exp_q [$];
  logic [3:0]  row;
  logic [36:0] front;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    mem_rd = '0; mem_data = '0; alu_rd = '0; alu_data = '0;
    q1_reg = '0; q2_reg = '0;

    // ---- reset state ----
    #3;
    check("rst_regWrite", regWrite, 0);
    check("rst_writeReg", writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_busy", busy, 0);
    check("rst_q1_hit", q1_hit, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);
`ifdef WB_STATS_EN
    check("rst_stat_commits", stat_commits, 0);
    check("rst_stat_stalls", stat_stalls, 0);
`endif
    step();
    reset = 1'b1;

    // ---- single ALU write ----
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    q1_reg = 5; q2_reg = 5;
    #1;
    $display("txn alu rd=5 data=deadbeef");
    check("single_alu_ready", alu_ready, 1);
    check("single_incoming_not_searched", q1_hit, 0);
    step();
    idle();
    #1;
    check("single_regWrite", regWrite, 1);
    check("single_writeReg", writeReg, 5);
    check("single_writeData", writeData, 32'hDEADBEEF);
    check("single_busy", busy, 1);
    check("single_q1_hit", q1_hit, 1);
    check("single_q2_data", q2_data, 32'hDEADBEEF);
    step();
    check("single_after_regWrite", regWrite, 0);
    check("single_after_busy", busy, 0);
    check("single_after_q1_hit", q1_hit, 0);
    check("single_after_q1_data", q1_data, 0);

    // ---- same-cycle load and ALU to the same register ----
    mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h22;
    q1_reg = 3; q2_reg = 4;
    $display("txn mem rd=3 data=11 + alu rd=3 data=22");
    step();
    idle();
    #1;
    check("order_first_writeReg", writeReg, 3);
    check("order_first_writeData", writeData, 32'h11);
    check("order_q1_hit", q1_hit, 1);
    check("order_q1_youngest", q1_data, 32'h22);
    check("order_q2_miss_hit", q2_hit, 0);
    check("order_q2_miss_data", q2_data, 0);
    step();
    check("order_second_regWrite", regWrite, 1);
    check("order_second_writeData", writeData, 32'h22);
    check("order_q1_after_commit", q1_data, 32'h22);
    step();
    check("order_done_busy", busy, 0);
    check("order_done_q1_hit", q1_hit, 0);

    // ---- ready/backpressure table with ordering model ----
    q1_reg = 0; q2_reg = 0;
    for (int i = 0; i < 7; i++) begin
      row = tbl[i];
      mem_valid = row[3]; mem_rd = 5'(i + 1);  mem_data = 32'h1000 + i;
      alu_valid = row[2]; alu_rd = 5'(i + 10); alu_data = 32'h2000 + i;
      #1;
      $display("txn row %0d mem_valid=%0b alu_valid=%0b", i, row[3], row[2]);
      check("tbl_mem_ready", mem_ready, row[1]);
      check("tbl_alu_ready", alu_ready, row[0]);
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        check("tbl_regWrite", regWrite, 1);
        check("tbl_writeReg", writeReg, front[36:32]);
        check("tbl_writeData", writeData, front[31:0]);
      end else begin
        check("tbl_regWrite_idle", regWrite, 0);
      end
      @(posedge clk);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (row[3] && row[1]) exp_q.push_back({mem_rd, mem_data});
      if (row[2] && row[0]) exp_q.push_back({alu_rd, alu_data});
      #1;
    end
    idle();
    #1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      front = exp_q[0];
      check("drain_regWrite", regWrite, 1);
      check("drain_writeReg", writeReg, front[36:32]);
      check("drain_writeData", writeData, front[31:0]);
      step();
      void'(exp_q.pop_front());
    end
    check("drain_busy", busy, 0);

    // ---- r0 filter ----
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    #1;
    $display("txn alu rd=0 data=ffff");
    check("r0_alu_ready", alu_ready, 1);
    step();
    idle();
    q1_reg = 0;
    #1;
    check("r0_regWrite", regWrite, 0);
    check("r0_busy", busy, 0);
    check("r0_q1_hit", q1_hit, 0);
    check("r0_q1_data", q1_data, 0);
    mem_valid = 1; mem_rd = 0; mem_data = 32'h77;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h70;
    $display("txn mem rd=0 + alu rd=7 data=70");
    step();
    idle();
    #1;
    check("r0_mix_writeReg", writeReg, 7);
    check("r0_mix_writeData", writeData, 32'h70);
    check("r0_mix_q1_hit", q1_hit, 0);
    step();
    check("r0_mix_single_slot", busy, 0);

    // ---- reset in the middle of operation ----
    mem_valid = 1; mem_rd = 1; mem_data = 32'hA1;
    alu_valid = 1; alu_rd = 2; alu_data = 32'hA2;
    step();
    mem_rd = 4; mem_data = 32'hA4;
    alu_rd = 6; alu_data = 32'hA6;
    step();
    idle();
    q1_reg = 6;
    #1;
    $display("txn reset with three pending");
    check("midrst_pre_q1_hit", q1_hit, 1);
    reset = 1'b0;
    #1;
    check("midrst_regWrite", regWrite, 0);
    check("midrst_busy", busy, 0);
    check("midrst_q1_hit", q1_hit, 0);
    check("midrst_writeData", writeData, 0);
    step();
    reset = 1'b1;
    #1;
    check("midrst_rel_regWrite", regWrite, 0);
    check("midrst_rel_busy", busy, 0);
    step();
    check("midrst_rel2_regWrite", regWrite, 0);
    check("midrst_rel2_mem_ready", mem_ready, 1);

`ifdef WB_STATS_EN
    // ---- statistics: 10 accepted writes, 4 stalled cycles ----
    for (int i = 0; i < 8; i++) begin
      mem_valid = (i != 6); mem_rd = 5'(i + 1);  mem_data = 32'h300 + i;
      alu_valid = (i != 7); alu_rd = 5'(i + 10); alu_data = 32'h400 + i;
      step();
    end
    idle();
    for (int c = 0; c < 20 && busy; c++) step();
    $display("txn stats commits=%0d stalls=%0d", stat_commits, stat_stalls);
    check("stat_commits", stat_commits, 10);
    check("stat_stalls", stat_stalls, 4);
    reset = 1'b0;
    #1;
    check("stat_commits_rst", stat_commits, 0);
    check("stat_stalls_rst", stat_stalls, 0);
    step();
    reset = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
